// File: rtl/ipr_mchan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ipr_mchan_fifo
// Brief    : Multi-channel synchronous FIFO. Each channel owns a private
//            circular buffer. Per-channel watchdog flush, bulk-level
//            interrupt, sticky overflow/underflow error flags.
// Revision : 1.0 - initial release
// ============================================================================
module ipr_mchan_fifo #(
  parameter int DSIZE          = 32,
  parameter int ASIZE          = 4,
  parameter int NUM_CH         = 4,
  parameter bit FALLTHROUGH    = 1'b1,
  parameter int WATCHDOG_LIMIT = 100,
  parameter int BULK_NUMBER    = 10,
  localparam int CW            = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid,
  input  logic [CW-1:0]               wr_ch,
  input  logic [DSIZE-1:0]            wr_data,
  output logic                        wr_ready,
  input  logic [CW-1:0]               rd_ch,
  input  logic                        rd_ready,
  output logic                        rd_valid,
  output logic [DSIZE-1:0]            rd_data,
  output logic [NUM_CH*(ASIZE+1)-1:0] ch_count,
  output logic [NUM_CH-1:0]           bulk_irq,
  output logic [NUM_CH-1:0]           wd_flush,
  input  logic                        err_clr,
  output logic                        error_flag
);

  localparam int DEPTH = 1 << ASIZE;
  // The watchdog never counts past LIMIT-1: the flush edge clears it.
  localparam int WDW   = (WATCHDOG_LIMIT > 1) ? $clog2(WATCHDOG_LIMIT) : 1;

  // Storage is intentionally not reset; pointers/counts define validity.
  logic [DSIZE-1:0]                mem [NUM_CH][DEPTH];
  logic [NUM_CH-1:0][ASIZE-1:0]    wr_ptr;
  logic [NUM_CH-1:0][ASIZE-1:0]    rd_ptr;
  logic [NUM_CH-1:0][ASIZE:0]      count;
  logic [NUM_CH-1:0][WDW-1:0]      wd_cnt;
  logic [NUM_CH-1:0]               ovf;
  logic [NUM_CH-1:0]               udf;
  logic [NUM_CH-1:0]               full;
  logic [NUM_CH-1:0]               empty;
  logic [NUM_CH-1:0]               push;
  logic [NUM_CH-1:0]               pop;
  logic [NUM_CH-1:0]               stall;
  logic [NUM_CH-1:0]               flush_now;
  logic [DSIZE-1:0]                head;

  // Per-channel status decode and channel-selected handshake/read muxing.
  always_comb begin
    wr_ready = 1'b0;
    rd_valid = 1'b0;
    head     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]      = (count[c] == (ASIZE+1)'(DEPTH));
      empty[c]     = (count[c] == '0);
      pop[c]       = rd_ready && (rd_ch == CW'(c)) && !empty[c];
      stall[c]     = !empty[c] && !pop[c];
      flush_now[c] = stall[c] && (wd_cnt[c] == WDW'(WATCHDOG_LIMIT - 1));
      bulk_irq[c]  = (count[c] >= (ASIZE+1)'(BULK_NUMBER));
      if (wr_ch == CW'(c)) begin
        // Registered count only: a same-cycle pop does not open a slot.
        wr_ready = !full[c] && !flush_now[c];
      end
      if (rd_ch == CW'(c)) begin
        rd_valid = !empty[c];
        head     = mem[c][rd_ptr[c]];
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      push[c] = wr_valid && wr_ready && (wr_ch == CW'(c));
    end
  end

  assign ch_count   = count;
  assign error_flag = |{ovf, udf};

  // Pointer, count, watchdog and sticky-error state for every channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wd_cnt   <= '0;
      wd_flush <= '0;
      ovf      <= '0;
      udf      <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush_now[c]) begin
          // Drop everything queued; no push or pop can coincide here.
          rd_ptr[c] <= wr_ptr[c];
          count[c]  <= '0;
          wd_cnt[c] <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
          if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
          if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
          else if (pop[c] && !push[c]) count[c] <= count[c] - 1'b1;
          wd_cnt[c] <= stall[c] ? wd_cnt[c] + 1'b1 : '0;
        end
        wd_flush[c] <= flush_now[c];
        // A fresh error in the same cycle takes priority over err_clr.
        ovf[c] <= (wr_valid && (wr_ch == CW'(c)) && full[c]) || (ovf[c] && !err_clr);
        udf[c] <= (rd_ready && (rd_ch == CW'(c)) && empty[c]) || (udf[c] && !err_clr);
      end
    end
  end

  // Buffer write port.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= wr_data;
    end
  end

  generate
    if (FALLTHROUGH) begin : g_ft
      assign rd_data = head;
    end else begin : g_reg
      logic [DSIZE-1:0] rd_q;
      // Capture the popped word; hold it between pops.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   rd_q <= '0;
        else if (rd_ready && rd_valid) rd_q <= head;
      end
      assign rd_data = rd_q;
    end
  endgenerate

endmodule
`default_nettype wire
